// File: rtl/regf_wb_arb_pkg.sv
// Shared write-back definitions for the register-file port-C path.
// The width defaults are common to regf_status and the register file.
package regf_wb_arb_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_t;

endpackage

// File: rtl/regf_wb_fifo.sv
// Memory-result FIFO (DEPTH x {addr,data}) feeding the port-C write-back arbiter.
// Pointers wrap modulo DEPTH; flush and reset both empty it in one cycle.
module regf_wb_fifo
  import regf_wb_arb_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_addr,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [AWIDTH-1:0] head_addr,
  output logic [DWIDTH-1:0] head_data,
  output logic [PWIDTH:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [PWIDTH:0] FULL_CNT = (PWIDTH+1)'(DEPTH);

  logic [AWIDTH+DWIDTH-1:0] store [DEPTH];
  logic [PWIDTH-1:0]        wr_ptr;
  logic [PWIDTH-1:0]        rd_ptr;
  logic [PWIDTH:0]          count_r;
  logic                     push_ok;
  logic                     pop_ok;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == '0);
  assign push_ok = push & ~full;
  // Pop looks only at the registered count, so an entry pushed this cycle cannot leave this cycle.
  assign pop_ok  = pop & ~empty;
  assign count   = count_r;

  assign head_addr = store[rd_ptr][AWIDTH+DWIDTH-1:DWIDTH];
  assign head_data = store[rd_ptr][DWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= {push_addr, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regf_wb_arb.sv
// Port-C write-back arbiter: ALU results (strict priority, no backpressure) merged with
// handshaked memory results buffered in a FIFO, into one registered write port.
module regf_wb_arb
  import regf_wb_arb_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              flush_pipeline,
  input  logic              alu_we,
  input  logic [AWIDTH-1:0] alu_addr,
  input  logic [DWIDTH-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_data,
  output logic              mem_ready,
  output logic              wec,
  output logic [AWIDTH-1:0] addrc,
  output logic [DWIDTH-1:0] datac,
  output logic              wb_pending,
  output logic [PWIDTH:0]   fifo_count
);

  wb_sel_t           sel;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AWIDTH-1:0] head_addr;
  logic [DWIDTH-1:0] head_data;
  logic [PWIDTH:0]   count;

  logic              wec_p1;
  logic [AWIDTH-1:0] addrc_p1;
  logic [DWIDTH-1:0] datac_p1;

  // No same-cycle pop credit: a full FIFO refuses even when it is draining this cycle.
  assign mem_ready = ~reset & ~flush_pipeline & ~fifo_full;
  assign push      = mem_valid & mem_ready;
  assign pop       = (sel == SEL_FIFO);

  regf_wb_fifo #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .PWIDTH (PWIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_pipeline),
    .push      (push),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Halted: the scoreboard ignores updates, so nothing may issue; an ALU write then is dropped.
  always_comb begin
    sel = SEL_NONE;
    if (!reset && !flush_pipeline && !halt) begin
      if (alu_we)           sel = SEL_ALU;
      else if (!fifo_empty) sel = SEL_FIFO;
    end
  end

  // ---- stage p1: registered port-C write ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wec_p1   <= 1'b0;
      addrc_p1 <= '0;
      datac_p1 <= '0;
    end else begin
      case (sel)
        SEL_ALU: begin
          wec_p1   <= 1'b1;
          addrc_p1 <= alu_addr;
          datac_p1 <= alu_data;
        end
        SEL_FIFO: begin
          wec_p1   <= 1'b1;
          addrc_p1 <= head_addr;
          datac_p1 <= head_data;
        end
        default: wec_p1 <= 1'b0;
      endcase
    end
  end

  assign wec        = wec_p1;
  assign addrc      = addrc_p1;
  assign datac      = datac_p1;
  assign fifo_count = count;
  assign wb_pending = ~fifo_empty;

endmodule
